// File: rtl/sub_cla_24_pipe_if.sv
// Purpose: handshake and data bundle for the pipelined 24-bit mantissa
//          subtractor.
// Signals:
//   iValid/oReady : input token handshake (producer -> subtractor)
//   iA, iB, iBin  : minuend, subtrahend, borrow in
//   oValid/iReady : result token handshake (subtractor -> consumer)
//   oD            : (A - B - Bin) mod 2^WIDTH
//   oBout, oNeg   : borrow out / result negative (always equal)
//   oMag          : |A - B - Bin|, WIDTH+1 bits
//   oZero         : true difference is exactly zero
// Modports: slave = subtractor side, master = producer/consumer side.
interface sub_cla_24_pipe_if #(
    parameter int WIDTH = 24
);
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iBin;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oD;
    logic             oBout;
    logic             oNeg;
    logic [WIDTH:0]   oMag;
    logic             oZero;

    modport slave (
        input  iValid, iA, iB, iBin, iReady,
        output oReady, oValid, oD, oBout, oNeg, oMag, oZero
    );

    modport master (
        output iValid, iA, iB, iBin, iReady,
        input  oReady, oValid, oD, oBout, oNeg, oMag, oZero
    );
endinterface

// File: rtl/sub_cla_24_pipe.sv
// Purpose: two-stage pipelined subtractor computing A - B - Bin as
//          A + ~B + ~Bin with 4-bit carry-lookahead groups. Stage 1 resolves
//          the low SPLIT bits, stage 2 the high bits plus sign, magnitude and
//          zero flags. Valid/ready flow control on both sides, 2 tokens max.
// Ports:
//   iClk   : clock, rising edge
//   iRst_n : asynchronous reset, active low
//   bus    : sub_cla_24_pipe_if.slave (handshakes, operands, results)

// N-bit adder built from 4-bit lookahead groups; carries ripple only inside
// a group, group carries are formed from group generate/propagate.
module sub_cla_24_pipe_cla #(
    parameter int N = 12
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N:0]   w_c;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic         w_gg;
    logic         w_gp;

    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c    = '0;
        w_c[0] = i_cin;
        w_gg   = 1'b0;
        w_gp   = 1'b1;
        for (int k = 0; k < N; k += 4) begin
            w_gg = 1'b0;
            w_gp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (k + j < N) begin
                    w_c[k+j+1] = w_g[k+j] | (w_p[k+j] & w_c[k+j]);
                    w_gg       = w_g[k+j] | (w_p[k+j] & w_gg);
                    w_gp       = w_gp & w_p[k+j];
                end
            end
            // group carry-out from lookahead terms (same value as the ripple)
            w_c[(k + 4 < N) ? (k + 4) : N] = w_gg | (w_gp & w_c[k]);
        end
        o_sum  = w_p ^ w_c[N-1:0];
        o_cout = w_c[N];
    end
endmodule

module sub_cla_24_pipe #(
    parameter int WIDTH = 24,
    parameter int SPLIT = 12
) (
    input logic               iClk,
    input logic               iRst_n,
    sub_cla_24_pipe_if.slave  bus
);
    localparam int HI = WIDTH - SPLIT;

    logic             w_load1;
    logic             w_load2;
    logic [SPLIT-1:0] w_sum_lo;
    logic             w_cout_lo;
    logic [HI-1:0]    w_sum_hi;
    logic             w_cout_hi;
    logic [WIDTH-1:0] w_d;
    logic             w_borrow;
    logic [WIDTH:0]   w_mag;
    logic             w_zero;

    logic             r_s1_v;
    logic [SPLIT-1:0] r_s1_d_lo;
    logic             r_s1_c;
    logic [HI-1:0]    r_s1_a_hi;
    logic [HI-1:0]    r_s1_nb_hi;

    logic             r_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic [WIDTH:0]   r_mag;
    logic             r_zero;

    // a stage may load when its content leaves (or it is empty)
    assign w_load2    = ~r_valid | bus.iReady;
    assign w_load1    = ~r_s1_v | w_load2;
    assign bus.oReady = w_load1;

    // low part: A + ~B + ~Bin
    sub_cla_24_pipe_cla #(.N(SPLIT)) u_cla_lo (
        .i_a    (bus.iA[SPLIT-1:0]),
        .i_b    (~bus.iB[SPLIT-1:0]),
        .i_cin  (~bus.iBin),
        .o_sum  (w_sum_lo),
        .o_cout (w_cout_lo)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_d_lo  <= '0;
            r_s1_c     <= 1'b0;
            r_s1_a_hi  <= '0;
            r_s1_nb_hi <= '0;
        end else if (w_load1) begin
            r_s1_v <= bus.iValid;
            if (bus.iValid) begin
                r_s1_d_lo  <= w_sum_lo;
                r_s1_c     <= w_cout_lo;
                r_s1_a_hi  <= bus.iA[WIDTH-1:SPLIT];
                r_s1_nb_hi <= ~bus.iB[WIDTH-1:SPLIT];
            end
        end
    end

    sub_cla_24_pipe_cla #(.N(HI)) u_cla_hi (
        .i_a    (r_s1_a_hi),
        .i_b    (r_s1_nb_hi),
        .i_cin  (r_s1_c),
        .o_sum  (w_sum_hi),
        .o_cout (w_cout_hi)
    );

    assign w_d      = {w_sum_hi, r_s1_d_lo};
    assign w_borrow = ~w_cout_hi;
    assign w_mag    = w_borrow ? ({1'b0, ~w_d} + 1'b1) : {1'b0, w_d};
    // a zero pattern with borrow set is -2^WIDTH, not zero
    assign w_zero   = (w_d == '0) & ~w_borrow;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_mag   <= '0;
            r_zero  <= 1'b0;
        end else if (w_load2) begin
            r_valid <= r_s1_v;
            if (r_s1_v) begin
                r_d    <= w_d;
                r_bout <= w_borrow;
                r_mag  <= w_mag;
                r_zero <= w_zero;
            end
        end
    end

    assign bus.oValid = r_valid;
    assign bus.oD     = r_d;
    assign bus.oBout  = r_bout;
    assign bus.oNeg   = r_bout;
    assign bus.oMag   = r_mag;
    assign bus.oZero  = r_zero;
endmodule

// File: tb/tb_sub_cla_24_pipe.sv
module tb_sub_cla_24_pipe;
    logic clk;
    logic rst_n;

    sub_cla_24_pipe_if #(.WIDTH(24)) bus ();

    sub_cla_24_pipe dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int emit_cnt = 0;
    bit rnd_on = 0;

    logic [51:0] exp_q[$];
    logic        prev_stall = 0;
    logic [52:0] snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // reference: exact integer difference, then derive every output from it
    function automatic logic [51:0] model(input logic [23:0] a, input logic [23:0] b, input logic bin);
        longint diff;
        logic [63:0] raw;
        logic [24:0] mag;
        diff = longint'(a) - longint'(b) - longint'(bin);
        raw  = diff;
        mag  = (diff < 0) ? 25'(-diff) : 25'(diff);
        return {raw[23:0], diff < 0, diff < 0, mag, diff == 0};
    endfunction

    function automatic logic [51:0] dut_out();
        return {bus.oD, bus.oBout, bus.oNeg, bus.oMag, bus.oZero};
    endfunction

    // scoreboard / compare process, samples on the falling edge
    always @(negedge clk) begin
        logic [52:0] cur;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            cur = {bus.oValid, dut_out()};
            if (prev_stall) chk("hold_stable", 64'(cur), 64'(snap));
            if (bus.oValid && bus.iReady) begin
                emit_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h required none", dut_out());
                end else begin
                    chk("result", 64'(dut_out()), 64'(exp_q.pop_front()));
                end
            end
            if (bus.iValid && bus.oReady) exp_q.push_back(model(bus.iA, bus.iB, bus.iBin));
            prev_stall = bus.oValid & ~bus.iReady;
            snap = cur;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) bus.iReady = ($urandom_range(0, 3) != 0);
        end
    end

    // present one token at posedge+1, return at posedge+1 after acceptance
    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic bin);
        int n;
        n = 0;
        bus.iA = a; bus.iB = b; bus.iBin = bin; bus.iValid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.oReady) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept required accept within 2000 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        bus.iA = 24'($urandom); bus.iB = 24'($urandom); bus.iBin = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.oValid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size() != 0 || bus.oValid), 64'd0);
    endtask

    // pipeline empty, iReady=1: result must appear exactly two edges later
    task automatic single(input string name, input logic [23:0] a, input logic [23:0] b, input logic bin,
                          input logic [23:0] ed, input logic eb, input logic [24:0] em, input logic ez);
        bus.iA = a; bus.iB = b; bus.iBin = bin; bus.iValid = 1'b1;
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        chk({name, "_early"}, 64'(bus.oValid), 64'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 64'(bus.oValid), 64'd1);
        chk({name, "_d"},     64'(bus.oD),     64'(ed));
        chk({name, "_bout"},  64'(bus.oBout),  64'(eb));
        chk({name, "_neg"},   64'(bus.oNeg),   64'(eb));
        chk({name, "_mag"},   64'(bus.oMag),   64'(em));
        chk({name, "_zero"},  64'(bus.oZero),  64'(ez));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rnd24();
        case ($urandom_range(0, 7))
            0:       return 24'h000000;
            1:       return 24'hFFFFFF;
            2:       return 24'h000FFF;
            3:       return 24'h001000;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        int base;
        logic [23:0] a;
        logic [23:0] b;
        rst_n = 1'b1;
        bus.iValid = 1'b0; bus.iReady = 1'b1;
        bus.iA = '0; bus.iB = '0; bus.iBin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.oValid), 64'd0);
        chk("rst_ready", 64'(bus.oReady), 64'd1);
        chk("rst_out",   64'(dut_out()),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        single("t1",  24'd125, 24'd11,  1'b0, 24'd114,     1'b0, 25'd114,        1'b0);
        single("t2a", 24'd127, 24'd105, 1'b1, 24'd21,      1'b0, 25'd21,         1'b0);
        single("t2b", 24'd255, 24'd255, 1'b1, 24'hFFFFFF,  1'b1, 25'd1,          1'b0);
        single("t3a", 24'd100, 24'd215, 1'b0, 24'hFFFF8D,  1'b1, 25'd115,        1'b0);
        single("t3b", 24'd0,   24'hFFFFFF, 1'b1, 24'd0,    1'b1, 25'h1000000,    1'b0);
        single("zero", 24'h123456, 24'h123455, 1'b1, 24'd0, 1'b0, 25'd0,         1'b1);

        // back-pressure: two accepts fill the pipe, then oReady drops
        bus.iReady = 1'b0;
        base = emit_cnt;
        send(24'd10, 24'd3, 1'b0);
        send(24'd20, 24'd30, 1'b1);
        @(negedge clk);
        chk("stall_oready", 64'(bus.oReady), 64'd0);
        chk("stall_ovalid", 64'(bus.oValid), 64'd1);
        @(posedge clk);
        #1;
        fork
            begin
                send(24'hFFFFFF, 24'd1, 1'b0);
                send(24'd0, 24'd0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.iReady = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(emit_cnt - base), 64'd4);

        // random traffic
        rnd_on = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            a = rnd24();
            b = ($urandom_range(0, 7) == 0) ? a : rnd24();
            send(a, b, 1'($urandom));
        end
        rnd_on = 0;
        @(posedge clk);
        #1 bus.iReady = 1'b1;
        drain();

        // reset with two tokens in flight
        bus.iReady = 1'b0;
        send(24'd7, 24'd9, 1'b0);
        send(24'd500, 24'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.oValid), 64'd0);
        chk("mid_rst_out",   64'(dut_out()),  64'd0);
        chk("mid_rst_ready", 64'(bus.oReady), 64'd1);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", 64'(bus.oValid), 64'd0);
        rst_n = 1'b1;
        bus.iReady = 1'b1;
        single("post_rst", 24'd125, 24'd11, 1'b0, 24'd114, 1'b0, 25'd114, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_empty", 64'(bus.oValid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
